// File: rtl/quad_span_writer.sv
`default_nettype none
// ============================================================================
//  Module   : quad_span_writer
//  Purpose  : Turns one scanline coverage mask (isInside) plus drawY and a
//             fill colour into masked CHUNK-pixel word writes, presented on
//             a valid/ready write port. One scanline per accepted start.
//  Ports    : Clk, Reset_n (sync, active-low)
//             start/drawY/isInside/color - scanline request, latched in IDLE
//             busy/done                  - sequencer status (done = 1-cycle pulse)
//             wr_valid/wr_ready          - write handshake
//             wr_addr/wr_mask/wr_data    - word address, pixel enables, colour
//  Config   : QUAD_SPAN_SKIP_EN - when defined, empty chunks are skipped by a
//             priority encoder instead of costing one idle cycle each.
//  Revision : 1.0 - initial release
// ============================================================================
module quad_span_writer #(
    parameter int WARP_WIDTH = 320,
    parameter int LINES      = 240,
    parameter int CHUNK      = 16,
    parameter int COLOR_W    = 8
) (
    input  logic                       Clk,
    input  logic                       Reset_n,
    input  logic                       start,
    input  logic [9:0]                 drawY,
    input  logic [WARP_WIDTH-1:0]      isInside,
    input  logic [COLOR_W-1:0]         color,
    output logic                       busy,
    output logic                       done,
    output logic                       wr_valid,
    input  logic                       wr_ready,
    output logic [12:0]                wr_addr,
    output logic [CHUNK-1:0]           wr_mask,
    output logic [CHUNK*COLOR_W-1:0]   wr_data
);

    localparam int c_chunks = WARP_WIDTH / CHUNK;
    localparam int c_k_w    = (c_chunks > 1) ? $clog2(c_chunks) : 1;
    localparam logic [c_k_w-1:0] c_last_k = c_k_w'(c_chunks - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t                     state_q, state_d;
    logic [c_k_w-1:0]           k_q, k_d;
    logic [WARP_WIDTH-1:0]      mask_q, mask_d;
    logic [8:0]                 y_q, y_d;      // only lines < 512 ever write
    logic [COLOR_W-1:0]         col_q, col_d;

    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic                       wr_valid_q, wr_valid_d;
    logic [12:0]                wr_addr_q, wr_addr_d;
    logic [CHUNK-1:0]           wr_mask_q, wr_mask_d;
    logic [CHUNK*COLOR_W-1:0]   wr_data_q, wr_data_d;

`ifdef QUAD_SPAN_SKIP_EN
    logic [c_k_w:0]             w_first;       // {found, index} for start
    logic [c_k_w:0]             w_next;        // {found, index} after k_q

    // One bit per chunk: does the chunk hold any covered pixel?
    function automatic logic [c_chunks-1:0] f_nonempty(input logic [WARP_WIDTH-1:0] m);
        logic [c_chunks-1:0] v;
        v = '0;
        for (int i = 0; i < c_chunks; i++) begin
            v[i] = |m[i*CHUNK +: CHUNK];
        end
        return v;
    endfunction

    // Lowest set chunk index at or above 'from'; MSB flags whether one exists.
    function automatic logic [c_k_w:0] f_find(input logic [c_chunks-1:0] v, input int from);
        logic [c_k_w:0] r;
        r = '0;
        for (int i = c_chunks - 1; i >= 0; i--) begin
            if (v[i] && (i >= from)) begin
                r = {1'b1, c_k_w'(i)};
            end
        end
        return r;
    endfunction

    assign w_first = f_find(f_nonempty(isInside), 0);
    assign w_next  = f_find(f_nonempty(mask_q), int'(k_q) + 1);
`endif

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        mask_d  = mask_q;
        y_d     = y_q;
        col_d   = col_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    mask_d = isInside;
                    y_d    = drawY[8:0];
                    col_d  = color;
                    if (drawY >= 10'(LINES)) begin
                        state_d = ST_DONE;
                    end else begin
`ifdef QUAD_SPAN_SKIP_EN
                        k_d     = w_first[c_k_w-1:0];
                        state_d = w_first[c_k_w] ? ST_ACTIVE : ST_DONE;
`else
                        k_d     = '0;
                        state_d = (|isInside) ? ST_ACTIVE : ST_DONE;
`endif
                    end
                end
            end
            ST_ACTIVE: begin
                // Hold everything while a presented word is not yet taken.
                if (!(wr_valid_q && !wr_ready)) begin
`ifdef QUAD_SPAN_SKIP_EN
                    k_d     = w_next[c_k_w-1:0];
                    state_d = w_next[c_k_w] ? ST_ACTIVE : ST_DONE;
                    if (!w_next[c_k_w]) begin
                        k_d = k_q;
                    end
`else
                    if (k_q == c_last_k) begin
                        state_d = ST_DONE;
                    end else begin
                        k_d = k_q + 1'b1;
                    end
`endif
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are precomputed from the next state so they leave flops.
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
        wr_valid_d = (state_d == ST_ACTIVE) && (|mask_d[int'(k_d)*CHUNK +: CHUNK]);
        wr_addr_d  = 13'(y_d) * 13'(c_chunks) + 13'(k_d);
        wr_mask_d  = wr_valid_d ? mask_d[int'(k_d)*CHUNK +: CHUNK] : '0;
        wr_data_d  = wr_valid_d ? {CHUNK{col_d}} : '0;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_q    <= ST_IDLE;
            k_q        <= '0;
            mask_q     <= '0;
            y_q        <= '0;
            col_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= '0;
            wr_mask_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            k_q        <= k_d;
            mask_q     <= mask_d;
            y_q        <= y_d;
            col_q      <= col_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            wr_mask_q  <= wr_mask_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_mask  = wr_mask_q;
    assign wr_data  = wr_data_q;

endmodule
`default_nettype wire

// File: tb/tb_quad_span_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_quad_span_writer
//  Purpose  : Self-checking bench for quad_span_writer. Expected word lists
//             and done timing come from a scanline-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_quad_span_writer;

`ifdef QUAD_SPAN_SKIP_EN
    localparam bit SKIP = 1'b1;
`else
    localparam bit SKIP = 1'b0;
`endif

    logic           Clk = 1'b0;
    logic           Reset_n;
    logic           start;
    logic [9:0]     drawY;
    logic [319:0]   isInside;
    logic [7:0]     color;
    logic           busy;
    logic           done;
    logic           wr_valid;
    logic           wr_ready;
    logic [12:0]    wr_addr;
    logic [15:0]    wr_mask;
    logic [127:0]   wr_data;

    int checks   = 0;
    int failures = 0;

    always #5 Clk = ~Clk;

    quad_span_writer dut (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .start    (start),
        .drawY    (drawY),
        .isInside (isInside),
        .color    (color),
        .busy     (busy),
        .done     (done),
        .wr_valid (wr_valid),
        .wr_ready (wr_ready),
        .wr_addr  (wr_addr),
        .wr_mask  (wr_mask),
        .wr_data  (wr_data)
    );

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // mode 0: ready always 1; 1: random ready; 2: 3-cycle stall on addr 3008
    task automatic run_line(input logic [319:0] m, input logic [9:0] y,
                            input logic [7:0] c, input int mode);
        logic [28:0] q[$];
        int          n_exp;
        int          stalls;
        int          stall_left;
        int          exp_done;
        bit          seen_done;
        logic        rdy;
        logic [15:0] seg;

        q.delete();
        if (y < 10'd240) begin
            for (int k = 0; k < 20; k++) begin
                seg = m[16*k +: 16];
                if (seg != 16'h0) q.push_back({13'(int'(y) * 20 + k), seg});
            end
        end
        n_exp = q.size();

        start    = 1'b1;
        drawY    = y;
        isInside = m;
        color    = c;
        tick();
        // Scramble request inputs: the DUT must work from its latched copy.
        start    = 1'b0;
        drawY    = 10'($urandom);
        isInside = {10{32'($urandom)}};
        color    = 8'($urandom);

        stalls     = 0;
        stall_left = 3;
        seen_done  = 1'b0;
        for (int cyc = 1; cyc <= 300 && !seen_done; cyc++) begin
            case (mode)
                0:       rdy = 1'b1;
                1:       rdy = ($urandom_range(0, 3) != 0);
                default: rdy = !(wr_valid && wr_addr == 13'd3008 && stall_left > 0);
            endcase
            if (mode == 2 && !rdy) stall_left--;
            wr_ready = rdy;

            check("busy_in_line", 128'(busy), 128'(1));
            if (wr_valid) begin
                if (q.size() == 0) begin
                    check("extra_word", 128'(wr_valid), 128'(0));
                end else begin
                    check("wr_addr", 128'(wr_addr), 128'(q[0][28:16]));
                    check("wr_mask", 128'(wr_mask), 128'(q[0][15:0]));
                    check("wr_data", wr_data, {16{c}});
                    if (rdy) void'(q.pop_front());
                    else     stalls++;
                end
            end else begin
                check("idle_mask", 128'(wr_mask), 128'(0));
                check("idle_data", wr_data, 128'(0));
            end
            if (done) begin
                seen_done = 1'b1;
                exp_done  = (n_exp == 0) ? 1 : ((SKIP ? n_exp : 20) + stalls + 1);
                check("done_cycle", 128'(cyc), 128'(exp_done));
                check("words_left", 128'(q.size()), 128'(0));
                if (mode == 2) check("stall_count", 128'(stalls), 128'(3));
            end
            tick();
        end
        if (!seen_done) check("done_timeout", 128'(seen_done), 128'(1));
        check("post_busy", 128'(busy), 128'(0));
        check("post_done", 128'(done), 128'(0));
        check("post_valid", 128'(wr_valid), 128'(0));
        wr_ready = 1'b1;
    endtask

    initial begin
        logic [319:0] m;
        logic [319:0] en;
        logic [9:0]   ry;

        Reset_n  = 1'b0;
        start    = 1'b1;
        drawY    = 10'd10;
        isInside = '1;
        color    = 8'hFF;
        wr_ready = 1'b1;
        repeat (3) tick();
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_valid", 128'(wr_valid), 128'(0));
        check("rst_addr", 128'(wr_addr), 128'(0));
        check("rst_mask", 128'(wr_mask), 128'(0));
        check("rst_data", wr_data, 128'(0));
        Reset_n = 1'b1;
        start   = 1'b0;
        tick();
        check("rel_busy", 128'(busy), 128'(0));
        check("rel_valid", 128'(wr_valid), 128'(0));

        // Span x=100..209 on line 150.
        m = '0;
        for (int i = 100; i <= 209; i++) m[i] = 1'b1;
        run_line(m, 10'd150, 8'h2A, 0);
        run_line(m, 10'd150, 8'h2A, 2);

        // Empty mask; out-of-range line with a full mask.
        run_line('0, 10'd50, 8'h33, 0);
        run_line('1, 10'd240, 8'h44, 0);

        // Full mask on the last valid line.
        run_line('1, 10'd239, 8'h99, 1);

        // Abort a full-mask line in cycle 4, then restart.
        start    = 1'b1;
        drawY    = 10'd5;
        isInside = '1;
        color    = 8'h11;
        wr_ready = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c < 4; c++) begin
            check("abort_no_done", 128'(done), 128'(0));
            tick();
        end
        check("abort_no_done", 128'(done), 128'(0));
        Reset_n = 1'b0;
        tick();
        check("abort_busy", 128'(busy), 128'(0));
        check("abort_done", 128'(done), 128'(0));
        check("abort_valid", 128'(wr_valid), 128'(0));
        check("abort_mask", 128'(wr_mask), 128'(0));
        Reset_n = 1'b1;
        tick();
        check("abort_after_done", 128'(done), 128'(0));
        run_line('1, 10'd77, 8'h5C, 1);

        // Randomized lines: sparse chunk patterns, random ready.
        for (int t = 0; t < 25; t++) begin
            for (int w = 0; w < 10; w++) m[32*w +: 32] = $urandom;
            en = '0;
            for (int k = 0; k < 20; k++) en[16*k +: 16] = ($urandom_range(0, 2) == 0) ? 16'hFFFF : 16'h0;
            if (t % 3 == 0) m = m & en;
            if (t % 7 == 3) m = '0;
            ry = (t % 9 == 5) ? 10'($urandom_range(240, 1023)) : 10'($urandom_range(0, 239));
            run_line(m, ry, 8'($urandom), 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
